// File: rtl/rf_operand_fetch.sv
// rf_operand_fetch: requester-side driver of a register file.
// Takes decoded instructions, stalls on busy sources via a per-register
// scoreboard, reads operands from the RF and hands them to a consumer
// through a valid/ready handshake. Writeback traffic is passed straight
// through to the RF write port and bypassed into operands read alongside it.
module rf_operand_fetch #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  // instruction intake
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [1:0]        rs_en,
  input  logic [ADDR_W-1:0] rd,
  input  logic              rd_en,
  // RF read ports
  output logic [1:0]        read_en,
  output logic [ADDR_W-1:0] raddr_0,
  output logic [ADDR_W-1:0] raddr_1,
  input  logic [DATA_W-1:0] rdata_0,
  input  logic [DATA_W-1:0] rdata_1,
  // writeback in, RF write port out
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  // operand delivery
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  output logic              op_rd_en
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // latched instruction fields
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [1:0]        rs_en_q, rs_en_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              rd_en_q, rd_en_d;

  // pending-destination scoreboard
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // writeback seen in the CHECK cycle: the RF read launched in that same
  // cycle returns pre-write data, so the written value is kept here
  logic              fwd_a_q, fwd_a_d;
  logic              fwd_b_q, fwd_b_d;
  logic [DATA_W-1:0] fwd_data_a_q, fwd_data_a_d;
  logic [DATA_W-1:0] fwd_data_b_q, fwd_data_b_d;

  // registered outputs
  logic              inst_ready_q, inst_ready_d;
  logic              op_valid_q, op_valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [ADDR_W-1:0] op_rd_q, op_rd_d;
  logic              op_rd_en_q, op_rd_en_d;

  // read enable is decided in the CHECK cycle from the live writeback
  logic [1:0] read_en_c;

  logic wb_hit_1_c;
  logic wb_hit_2_c;
  logic hazard_c;

  // source hazard: busy and not being cleared by a writeback this cycle
  always_comb begin
    wb_hit_1_c = wb_valid && (wb_addr == rs1_q);
    wb_hit_2_c = wb_valid && (wb_addr == rs2_q);
    hazard_c   = (rs_en_q[0] && busy_q[rs1_q] && !wb_hit_1_c) ||
                 (rs_en_q[1] && busy_q[rs2_q] && !wb_hit_2_c);
  end

  // next-state, scoreboard update and operand capture
  always_comb begin
    state_d      = state_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rs_en_d      = rs_en_q;
    rd_d         = rd_q;
    rd_en_d      = rd_en_q;
    busy_d       = busy_q;
    fwd_a_d      = fwd_a_q;
    fwd_b_d      = fwd_b_q;
    fwd_data_a_d = fwd_data_a_q;
    fwd_data_b_d = fwd_data_b_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_rd_d      = op_rd_q;
    op_rd_en_d   = op_rd_en_q;
    read_en_c    = 2'b00;

    // writeback clears first so a same-cycle set below takes priority
    if (wb_valid) begin
      busy_d[wb_addr] = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (inst_valid) begin
          rs1_d   = rs1;
          rs2_d   = rs2;
          rs_en_d = rs_en;
          rd_d    = rd;
          rd_en_d = rd_en;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!hazard_c) begin
          read_en_c    = rs_en_q;
          fwd_a_d      = rs_en_q[0] && wb_hit_1_c;
          fwd_b_d      = rs_en_q[1] && wb_hit_2_c;
          fwd_data_a_d = wb_data;
          fwd_data_b_d = wb_data;
          if (rd_en_q) begin
            busy_d[rd_q] = 1'b1;
          end
          state_d = READ;
        end
      end
      READ: begin
        if (!rs_en_q[0]) begin
          op_a_d = '0;
        end else if (wb_hit_1_c) begin
          op_a_d = wb_data;
        end else if (fwd_a_q) begin
          op_a_d = fwd_data_a_q;
        end else begin
          op_a_d = rdata_0;
        end
        if (!rs_en_q[1]) begin
          op_b_d = '0;
        end else if (wb_hit_2_c) begin
          op_b_d = wb_data;
        end else if (fwd_b_q) begin
          op_b_d = fwd_data_b_q;
        end else begin
          op_b_d = rdata_1;
        end
        op_rd_d    = rd_q;
        op_rd_en_d = rd_en_q;
        state_d    = HOLD;
      end
      HOLD: begin
        if (op_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    inst_ready_d = (state_d == IDLE);
    op_valid_d   = (state_d == HOLD);
  end

  // state and datapath registers; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs_en_q      <= '0;
      rd_q         <= '0;
      rd_en_q      <= 1'b0;
      busy_q       <= '0;
      fwd_a_q      <= 1'b0;
      fwd_b_q      <= 1'b0;
      fwd_data_a_q <= '0;
      fwd_data_b_q <= '0;
      inst_ready_q <= 1'b1;
      op_valid_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_rd_q      <= '0;
      op_rd_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rs_en_q      <= rs_en_d;
      rd_q         <= rd_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      fwd_data_a_q <= fwd_data_a_d;
      fwd_data_b_q <= fwd_data_b_d;
      inst_ready_q <= inst_ready_d;
      op_valid_q   <= op_valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_rd_q      <= op_rd_d;
      op_rd_en_q   <= op_rd_en_d;
    end
  end

  // output mapping; RF write is suppressed while in reset
  always_comb begin
    inst_ready = inst_ready_q;
    read_en    = read_en_c;
    raddr_0    = rs1_q;
    raddr_1    = rs2_q;
    write_en   = wb_valid && reset_n;
    waddr      = wb_addr;
    wdata      = wb_data;
    op_valid   = op_valid_q;
    op_a       = op_a_q;
    op_b       = op_b_q;
    op_rd      = op_rd_q;
    op_rd_en   = op_rd_en_q;
  end

endmodule
